// File: rtl/quad_step_decoder_pkg.sv
// Shared types and constants for the quadrature step decoder and its counter.
// Pure declarations: no logic, no latency, no flow control.
package quad_step_decoder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } dec_state_t;

  // Quadrature states named {A,B}; forward order is Q00 -> Q10 -> Q11 -> Q01 -> Q00.
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  localparam int RES_EDGE  = 4;
  localparam int RES_CYCLE = 1;

  localparam int DEFAULT_M = 4;

  function automatic logic [1:0] q_fwd(input logic [1:0] q);
    case (q)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// One-bit synchroniser plus run-length glitch filter for an asynchronous encoder pin.
// Latency SYNC_STAGES+FILT_LEN cycles from pin edge to filtered edge; no backpressure.
module qdec_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
      run_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // The FILT_LEN-th consecutive differing cycle flips the output.
      if (synced == dout) begin
        run_q <= '0;
      end else if (run_q == CW'(FILT_LEN - 1)) begin
        run_q <= '0;
        dout  <= ~dout;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature a/b/idx to up/down counter controls (ce/up/L/di) with sticky sequence-error flag.
// Latency SYNC_STAGES+FILT_LEN+1 cycles pin to ce/L; all outputs registered, no backpressure.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int M           = DEFAULT_M,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int RES         = RES_EDGE,
  parameter int LOAD_VAL    = 0,
  parameter int IDX_EN      = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         a,
  input  logic         b,
  input  logic         idx,
  input  logic         err_clr,
  output logic         ce,
  output logic         up,
  output logic         L,
  output logic [M-1:0] di,
  output logic         err
);

  localparam int INIT_N = SYNC_STAGES + FILT_LEN;
  localparam int ICW    = $clog2(INIT_N + 1);

  logic             af, bf, idxf;
  logic [1:0]       cur;
  dec_state_t       state_q, state_d;
  logic [ICW-1:0]   init_q, init_d;
  logic [1:0]       prev_q, prev_d;
  logic             idx_q;
  logic             ce_d, up_d, l_d, err_d;
  logic             fwd, rev, bad;

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .clr_n(clr_n), .din(a), .dout(af)
  );
  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .clr_n(clr_n), .din(b), .dout(bf)
  );
  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_idx (
    .clk(clk), .clr_n(clr_n), .din(idx), .dout(idxf)
  );

  assign cur = {af, bf};
  assign di  = M'(LOAD_VAL);

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    prev_d  = prev_q;
    ce_d    = 1'b0;
    up_d    = up;
    l_d     = 1'b0;
    err_d   = err;
    fwd     = 1'b0;
    rev     = 1'b0;
    bad     = 1'b0;
    case (state_q)
      ST_INIT: begin
        // One cycle beyond the pipeline depth so prev sees the settled filter outputs.
        if (init_q == ICW'(INIT_N)) begin
          state_d = ST_TRACK;
          prev_d  = cur;
        end else begin
          init_d = init_q + ICW'(1);
        end
      end
      ST_TRACK: begin
        prev_d = cur;
        fwd    = (cur == q_fwd(prev_q));
        rev    = (prev_q == q_fwd(cur));
        bad    = (cur != prev_q) && !fwd && !rev;
        if (RES == RES_EDGE) ce_d = fwd || rev;
        else                 ce_d = (fwd && cur == Q00) || (rev && prev_q == Q00);
        if (ce_d) up_d = fwd;
        l_d = (IDX_EN != 0) && idxf && !idx_q;
      end
      default: state_d = ST_INIT;
    endcase
    if (err_clr) err_d = 1'b0;
    if (bad)     err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      prev_q  <= Q00;
      idx_q   <= 1'b0;
      ce      <= 1'b0;
      up      <= 1'b1;
      L       <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      prev_q  <= prev_d;
      idx_q   <= idxf;
      ce      <= ce_d;
      up      <= up_d;
      L       <= l_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Randomized bench for quad_step_decoder against a position-arithmetic reference model.
module tb_quad_step_decoder;
  import quad_step_decoder_pkg::*;

  logic clk = 1'b0;
  logic clr_n, a, b, idx, err_clr;
  logic ce4, up4, l4, err4; logic [3:0] di4;
  logic ce1, up1, l1, err1; logic [3:0] di1;
  logic ce0, up0, l0, err0; logic [3:0] di0;

  always #5 clk = ~clk;

  quad_step_decoder #(.RES(4), .LOAD_VAL(5), .IDX_EN(1)) dut4 (
    .clk(clk), .clr_n(clr_n), .a(a), .b(b), .idx(idx), .err_clr(err_clr),
    .ce(ce4), .up(up4), .L(l4), .di(di4), .err(err4));
  quad_step_decoder #(.RES(1), .LOAD_VAL(0), .IDX_EN(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .a(a), .b(b), .idx(idx), .err_clr(err_clr),
    .ce(ce1), .up(up1), .L(l1), .di(di1), .err(err1));
  quad_step_decoder #(.RES(4), .LOAD_VAL(0), .IDX_EN(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .a(a), .b(b), .idx(idx), .err_clr(err_clr),
    .ce(ce0), .up(up0), .L(l0), .di(di0), .err(err0));

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected (e*) and observed (o*) pulse cycles; *u holds the up value of each pulse.
  int e4c[$], e1c[$], elc[$], o4c[$], o1c[$], o0c[$], olc[$], ol1c[$], ol0c[$];
  logic e4u[$], e1u[$], o4u[$], o1u[$], o0u[$];

  always @(posedge clk) begin
    #1;
    if (ce4) begin o4c.push_back(cyc); o4u.push_back(up4); end
    if (ce1) begin o1c.push_back(cyc); o1u.push_back(up1); end
    if (ce0) begin o0c.push_back(cyc); o0u.push_back(up0); end
    if (l4) olc.push_back(cyc);
    if (l1) ol1c.push_back(cyc);
    if (l0) ol0c.push_back(cyc);
  end

  // Reference model: a quadrature state is a position 0..3 on the forward circle.
  logic [1:0] cur_q;
  logic       cur_ix;

  function automatic int qpos(input logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] qat(input int p);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b10, 2'b11, 2'b01};
    return tbl[p % 4];
  endfunction

  task automatic clear_obs();
    e4c.delete(); e4u.delete(); e1c.delete(); e1u.delete(); elc.delete();
    o4c.delete(); o4u.delete(); o1c.delete(); o1u.delete(); o0c.delete(); o0u.delete();
    olc.delete(); ol1c.delete(); ol0c.delete();
  endtask

  task automatic move(input logic [1:0] q, input logic ix, input int dwell);
    int d;
    @(negedge clk);
    d = (qpos(q) - qpos(cur_q) + 4) % 4;
    if (d == 1) begin
      e4c.push_back(cyc + 7); e4u.push_back(1'b1);
      if (qpos(q) == 0) begin e1c.push_back(cyc + 7); e1u.push_back(1'b1); end
    end else if (d == 3) begin
      e4c.push_back(cyc + 7); e4u.push_back(1'b0);
      if (qpos(q) == 3) begin e1c.push_back(cyc + 7); e1u.push_back(1'b0); end
    end
    if (ix && !cur_ix) elc.push_back(cyc + 7);
    {a, b} = q; idx = ix; cur_q = q; cur_ix = ix;
    repeat (dwell - 1) @(negedge clk);
  endtask

  task automatic go_home();
    while (cur_q != 2'b00) move(qat(qpos(cur_q) + 1), 1'b0, 8);
    repeat (10) @(negedge clk);
    clear_obs();
  endtask

  task automatic test_reset();
    clr_n = 1'b0; a = 1'b1; b = 1'b1; idx = 1'b0; err_clr = 1'b0;
    cur_q = 2'b11; cur_ix = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ce4, up4, l4, err4} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_outputs: ce/up/L/err got %b want 0100", {ce4, up4, l4, err4});
    end
    n_checks++;
    if (di4 !== 4'd5 || di0 !== 4'd0 || di1 !== 4'd0) begin
      n_fail++; $display("FAIL reset_di: got %0d/%0d/%0d want 5/0/0", di4, di1, di0);
    end
    clr_n = 1'b1;
    clear_obs();
    repeat (20) @(negedge clk);
    n_checks++;
    if (o4c.size() + o1c.size() + olc.size() !== 0) begin
      n_fail++; $display("FAIL reset_no_pulse: got %0d ce/L pulses want 0", o4c.size() + o1c.size() + olc.size());
    end
    n_checks++;
    if (dut4.prev_q !== 2'b11 || dut4.state_q !== ST_TRACK) begin
      n_fail++; $display("FAIL reset_prev: prev %b state %0d want 11 TRACK", dut4.prev_q, dut4.state_q);
    end
    n_checks++;
    if (err4 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err4); end
  endtask

  task automatic test_forward_reverse();
    go_home();
    for (int i = 1; i <= 4; i++) move(qat(i), 1'b0, 10);
    for (int i = 3; i >= 0; i--) move(qat(i), 1'b0, 10);
    repeat (10) @(negedge clk);
    n_checks++;
    if (o4c.size() !== e4c.size() || e4c.size() !== 8) begin
      n_fail++; $display("FAIL fr_count: got %0d pulses want %0d (8)", o4c.size(), e4c.size());
    end
    for (int i = 0; i < e4c.size() && i < o4c.size(); i++) begin
      n_checks++;
      if (o4c[i] !== e4c[i] || o4u[i] !== e4u[i]) begin
        n_fail++; $display("FAIL fr_pulse[%0d]: got cyc %0d up %b want cyc %0d up %b", i, o4c[i], o4u[i], e4c[i], e4u[i]);
      end
    end
  endtask

  task automatic test_res1();
    go_home();
    for (int i = 1; i <= 8; i++) move(qat(i), 1'b0, $urandom_range(5, 12));
    for (int i = 7; i >= 4; i--) move(qat(i), 1'b0, $urandom_range(5, 12));
    repeat (10) @(negedge clk);
    n_checks++;
    if (o1c.size() !== e1c.size() || e1c.size() !== 3) begin
      n_fail++; $display("FAIL res1_count: got %0d pulses want %0d (3)", o1c.size(), e1c.size());
    end
    for (int i = 0; i < e1c.size() && i < o1c.size(); i++) begin
      n_checks++;
      if (o1c[i] !== e1c[i] || o1u[i] !== e1u[i]) begin
        n_fail++; $display("FAIL res1_pulse[%0d]: got cyc %0d up %b want cyc %0d up %b", i, o1c[i], o1u[i], e1c[i], e1u[i]);
      end
    end
  endtask

  task automatic test_glitch_err();
    go_home();
    @(negedge clk); a = 1'b1;
    repeat (3) @(negedge clk); a = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (o4c.size() !== 0 || err4 !== 1'b0) begin
      n_fail++; $display("FAIL glitch: got %0d pulses err %b want 0 pulses err 0", o4c.size(), err4);
    end
    move(2'b11, 1'b0, 10);
    n_checks++;
    if ({err4, err1, err0} !== 3'b111 || o4c.size() !== 0) begin
      n_fail++; $display("FAIL illegal_step: err %b pulses %0d want 111 and 0", {err4, err1, err0}, o4c.size());
    end
    @(negedge clk); {a, b} = 2'b00; cur_q = 2'b00;
    repeat (6) @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_checks++;
    if (err4 !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", err4); end
    repeat (5) @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_checks++;
    if ({err4, err1, err0} !== 3'b000 || o4c.size() !== 0) begin
      n_fail++; $display("FAIL err_clr: err %b pulses %0d want 000 and 0", {err4, err1, err0}, o4c.size());
    end
  endtask

  task automatic test_index();
    go_home();
    move(2'b10, 1'b1, 6);
    move(2'b11, 1'b0, 10);
    repeat (8) @(negedge clk);
    n_checks++;
    if (olc.size() !== 1 || elc.size() !== 1 || ol1c.size() !== 1 || ol0c.size() !== 0) begin
      n_fail++; $display("FAIL idx_count: L pulses %0d/%0d/%0d want 1/1/0", olc.size(), ol1c.size(), ol0c.size());
    end else begin
      n_checks++;
      if (olc[0] !== elc[0] || ol1c[0] !== elc[0]) begin
        n_fail++; $display("FAIL idx_cycle: got %0d/%0d want %0d", olc[0], ol1c[0], elc[0]);
      end
    end
    n_checks++;
    if (o4c.size() !== 2 || o4c[0] !== e4c[0] || o4c[1] !== e4c[1]) begin
      n_fail++; $display("FAIL idx_ce: got %0d pulses want ce with L at cyc %0d", o4c.size(), e4c[0]);
    end
    n_checks++;
    if (di4 !== 4'd5) begin n_fail++; $display("FAIL idx_di: got %0d want 5", di4); end
  endtask

  task automatic test_random_walk();
    int p, r;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      p = qpos(cur_q);
      r = $urandom_range(0, 2);
      move(qat(p + (r == 0 ? 1 : (r == 1 ? 3 : 0))), 1'b0, $urandom_range(5, 12));
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (o4c.size() !== e4c.size() || o0c.size() !== e4c.size() || o1c.size() !== e1c.size()) begin
      n_fail++; $display("FAIL walk_count: got %0d/%0d/%0d want %0d/%0d/%0d",
                         o4c.size(), o0c.size(), o1c.size(), e4c.size(), e4c.size(), e1c.size());
    end
    for (int i = 0; i < e4c.size() && i < o4c.size() && i < o0c.size(); i++) begin
      n_checks++;
      if (o4c[i] !== e4c[i] || o4u[i] !== e4u[i] || o0c[i] !== e4c[i] || o0u[i] !== e4u[i]) begin
        n_fail++; $display("FAIL walk4[%0d]: got cyc %0d up %b want cyc %0d up %b", i, o4c[i], o4u[i], e4c[i], e4u[i]);
      end
    end
    for (int i = 0; i < e1c.size() && i < o1c.size(); i++) begin
      n_checks++;
      if (o1c[i] !== e1c[i] || o1u[i] !== e1u[i]) begin
        n_fail++; $display("FAIL walk1[%0d]: got cyc %0d up %b want cyc %0d up %b", i, o1c[i], o1u[i], e1c[i], e1u[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] q;
    repeat (10) @(negedge clk);
    q = qat(qpos(cur_q) + 3);
    @(negedge clk); {a, b} = q; cur_q = q;
    repeat (7) @(negedge clk);
    n_checks++;
    if (ce4 !== 1'b1 || up4 !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: ce %b up %b want 1 0", ce4, up4);
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({ce4, up4, l4, err4} !== 4'b0100) begin
      n_fail++; $display("FAIL mid_async: ce/up/L/err got %b want 0100", {ce4, up4, l4, err4});
    end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    clear_obs();
    repeat (20) @(negedge clk);
    n_checks++;
    if (o4c.size() + o1c.size() + o0c.size() !== 0) begin
      n_fail++; $display("FAIL mid_restart: got %0d spurious pulses want 0", o4c.size() + o1c.size() + o0c.size());
    end
    move(qat(qpos(cur_q) + 1), 1'b0, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (o4c.size() !== 1 || e4c.size() !== 1 || o4c[0] !== e4c[0] || o4u[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_resume: got %0d pulses want 1 at cyc %0d up 1", o4c.size(), e4c[0]);
    end
  endtask

  initial begin
    test_reset();
    test_forward_reverse();
    test_res1();
    test_glitch_err();
    test_index();
    test_random_walk();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
